// File: rtl/ald_pkg.sv
// rtl/ald_pkg.sv - shared state codes, valve masks and defaults for the ALD cycle sequencer
package ald_pkg;

    localparam int unsigned TICK_DIV_DEFAULT = 50000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PREHEAT = 3'd1,
        ST_PULSE_A = 3'd2,
        ST_PURGE_A = 3'd3,
        ST_PULSE_B = 3'd4,
        ST_PURGE_B = 3'd5,
        ST_DONE    = 3'd6,
        ST_ABORT   = 3'd7
    } ald_state_e;

    typedef struct packed {
        logic heater_en;
        logic vv1;
        logic sv3;
        logic sv2;
        logic sv1;
    } valve_mask_t;

    localparam valve_mask_t MASK_OFF     = '{heater_en: 1'b0, vv1: 1'b0, sv3: 1'b0, sv2: 1'b0, sv1: 1'b0};
    localparam valve_mask_t MASK_PREHEAT = '{heater_en: 1'b1, vv1: 1'b1, sv3: 1'b0, sv2: 1'b0, sv1: 1'b0};
    localparam valve_mask_t MASK_PULSE_A = '{heater_en: 1'b1, vv1: 1'b1, sv3: 1'b0, sv2: 1'b0, sv1: 1'b1};
    localparam valve_mask_t MASK_PURGE   = '{heater_en: 1'b1, vv1: 1'b1, sv3: 1'b0, sv2: 1'b1, sv1: 1'b0};
    localparam valve_mask_t MASK_PULSE_B = '{heater_en: 1'b1, vv1: 1'b1, sv3: 1'b1, sv2: 1'b0, sv1: 1'b0};
    localparam valve_mask_t MASK_ABORT   = '{heater_en: 1'b0, vv1: 1'b1, sv3: 1'b0, sv2: 1'b1, sv1: 1'b0};

    // DONE keeps everything closed so a zero-cycle run never moves a valve.
    function automatic valve_mask_t state_mask(input ald_state_e s);
        valve_mask_t m;
        case (s)
            ST_PREHEAT: m = MASK_PREHEAT;
            ST_PULSE_A: m = MASK_PULSE_A;
            ST_PURGE_A: m = MASK_PURGE;
            ST_PULSE_B: m = MASK_PULSE_B;
            ST_PURGE_B: m = MASK_PURGE;
            ST_ABORT:   m = MASK_ABORT;
            default:    m = MASK_OFF;
        endcase
        return m;
    endfunction

    // Break-before-make gap: all gas valves shut, vacuum and heater untouched.
    function automatic valve_mask_t close_gas(input valve_mask_t m);
        valve_mask_t r;
        r     = m;
        r.sv1 = 1'b0;
        r.sv2 = 1'b0;
        r.sv3 = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/ald_tick_timer.sv
// rtl/ald_tick_timer.sv - tick prescaler plus dwell down-counter
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   load_i          restart prescaler and load dwell_i ticks (0 treated as 1)
//   restart_i       restart prescaler and stop the dwell counter
//   dwell_i         dwell length in ticks
//   expired_o       high during the last clk cycle of the loaded dwell
module ald_tick_timer
    import ald_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT,
    parameter int unsigned CNT_W    = 17
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             restart_i,
    input  logic [CNT_W-1:0] dwell_i,
    output logic             expired_o
);

    localparam int unsigned   PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]    presc_q, presc_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic             tick_end;

    assign tick_end  = (presc_q == PRESC_LAST);
    // Firing on the final cycle of the final tick lets the caller change
    // state on that edge, so the dwell spans exactly T * TICK_DIV cycles.
    assign expired_o = (dwell_q == CNT_W'(1)) && tick_end;

    always_comb begin
        presc_d = presc_q;
        dwell_d = dwell_q;
        if (load_i) begin
            presc_d = '0;
            dwell_d = (dwell_i == '0) ? CNT_W'(1) : dwell_i;
        end else if (restart_i) begin
            presc_d = '0;
            dwell_d = '0;
        end else if (dwell_q != '0) begin
            if (tick_end) begin
                presc_d = '0;
                dwell_d = dwell_q - CNT_W'(1);
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_q <= '0;
            dwell_q <= '0;
        end else begin
            presc_q <= presc_d;
            dwell_q <= dwell_d;
        end
    end

endmodule

// File: rtl/ald_cycle_sequencer.sv
// rtl/ald_cycle_sequencer.sv - timed ALD cycle controller (heater interlock, A/B pulse-purge cycles)
// Ports:
//   clk, rst                          clock, asynchronous active-low reset
//   start, stop, temp_ok              front-panel / interlock levels (synchronised here)
//   t_pulse_a, t_purge_a, t_pulse_b,  dwell times in ticks, latched at start
//   t_purge_b, n_cycles               (t_purge_a also sets the abort purge length)
//   sv1, sv2, sv3, vv1, heater_en     registered valve and heater drives
//   busy, done, fault                 run status (fault sticky until next start)
//   state, cycle_count                state code and completed cycles, for LEDs
module ald_cycle_sequencer
    import ald_pkg::*;
#(
    parameter int unsigned TICK_DIV   = TICK_DIV_DEFAULT,
    parameter int unsigned TIME_W     = 16,
    parameter int unsigned CYCLE_W    = 8,
    parameter int unsigned PREHEAT_TO = 60000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               temp_ok,
    input  logic [TIME_W-1:0]  t_pulse_a,
    input  logic [TIME_W-1:0]  t_purge_a,
    input  logic [TIME_W-1:0]  t_pulse_b,
    input  logic [TIME_W-1:0]  t_purge_b,
    input  logic [CYCLE_W-1:0] n_cycles,
    output logic               sv1,
    output logic               sv2,
    output logic               sv3,
    output logic               vv1,
    output logic               heater_en,
    output logic               busy,
    output logic               done,
    output logic               fault,
    output logic [2:0]         state,
    output logic [CYCLE_W-1:0] cycle_count
);

    localparam int unsigned CNT_W = TIME_W + 1;

    // Input synchronisers. The start chain resets to 1 so a button held
    // through reset has to be released and pressed again to start a run.
    logic start_s1_q, start_s2_q, start_prev_q;
    logic stop_s1_q, stop_s2_q;
    logic temp_s1_q, temp_s2_q;
    logic start_rise;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_s1_q   <= 1'b1;
            start_s2_q   <= 1'b1;
            start_prev_q <= 1'b1;
            stop_s1_q    <= 1'b0;
            stop_s2_q    <= 1'b0;
            temp_s1_q    <= 1'b0;
            temp_s2_q    <= 1'b0;
        end else begin
            start_s1_q   <= start;
            start_s2_q   <= start_s1_q;
            start_prev_q <= start_s2_q;
            stop_s1_q    <= stop;
            stop_s2_q    <= stop_s1_q;
            temp_s1_q    <= temp_ok;
            temp_s2_q    <= temp_s1_q;
        end
    end

    assign start_rise = start_s2_q & ~start_prev_q;

    // Run parameters captured at start.
    logic [TIME_W-1:0]  t_pulse_a_q, t_purge_a_q, t_pulse_b_q, t_purge_b_q;
    logic [CYCLE_W-1:0] n_cycles_q;

    ald_state_e         state_q, state_d;
    ald_state_e         gap_tgt_q, gap_tgt_d;
    logic               gap_q, gap_d;
    logic [CYCLE_W-1:0] cycle_count_q;
    logic               fault_q, busy_q, done_q;
    valve_mask_t        mask_q, mask_d;

    logic               accept, count_inc, in_cycle, abort_req;
    logic               tmr_load, tmr_restart, tmr_expired;
    logic [CNT_W-1:0]   tmr_dwell;

    always_comb begin
        state_d   = state_q;
        gap_d     = 1'b0;
        gap_tgt_d = gap_tgt_q;
        accept    = 1'b0;
        count_inc = 1'b0;
        in_cycle  = (state_q == ST_PULSE_A) || (state_q == ST_PURGE_A) ||
                    (state_q == ST_PULSE_B) || (state_q == ST_PURGE_B);
        abort_req = stop_s2_q || (in_cycle && !temp_s2_q);

        unique case (state_q)
            ST_IDLE: begin
                // stop beats a simultaneous start: the run is not accepted.
                if (start_rise && !stop_s2_q) begin
                    accept  = 1'b1;
                    state_d = (n_cycles == '0) ? ST_DONE : ST_PREHEAT;
                end
            end
            ST_PREHEAT: begin
                if (stop_s2_q)        state_d = ST_ABORT;
                else if (temp_s2_q)   state_d = ST_PULSE_A;
                else if (tmr_expired) state_d = ST_ABORT;
            end
            ST_PULSE_A, ST_PULSE_B: begin
                // A pulse never hands straight to the next state: one
                // all-closed gap cycle is spent first, outside the dwell.
                if (gap_q) begin
                    state_d = abort_req ? ST_ABORT : gap_tgt_q;
                end else if (abort_req) begin
                    gap_d     = 1'b1;
                    gap_tgt_d = ST_ABORT;
                end else if (tmr_expired) begin
                    gap_d     = 1'b1;
                    gap_tgt_d = (state_q == ST_PULSE_A) ? ST_PURGE_A : ST_PURGE_B;
                end
            end
            ST_PURGE_A: begin
                if (abort_req)        state_d = ST_ABORT;
                else if (tmr_expired) state_d = ST_PULSE_B;
            end
            ST_PURGE_B: begin
                if (abort_req) begin
                    state_d = ST_ABORT;
                end else if (tmr_expired) begin
                    count_inc = 1'b1;
                    state_d   = ((cycle_count_q + CYCLE_W'(1)) == n_cycles_q) ? ST_DONE : ST_PULSE_A;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ABORT: begin
                if (tmr_expired) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Timer is reloaded on every state entry so the prescaler phase never
    // carries over; gap cycles and idle states hold it stopped.
    always_comb begin
        tmr_load    = 1'b0;
        tmr_restart = 1'b0;
        tmr_dwell   = '0;
        if (gap_d && !gap_q) begin
            tmr_restart = 1'b1;
        end else if (state_d != state_q) begin
            case (state_d)
                ST_PREHEAT: begin tmr_load = 1'b1; tmr_dwell = CNT_W'(PREHEAT_TO);  end
                ST_PULSE_A: begin tmr_load = 1'b1; tmr_dwell = {1'b0, t_pulse_a_q}; end
                ST_PURGE_A: begin tmr_load = 1'b1; tmr_dwell = {1'b0, t_purge_a_q}; end
                ST_PULSE_B: begin tmr_load = 1'b1; tmr_dwell = {1'b0, t_pulse_b_q}; end
                ST_PURGE_B: begin tmr_load = 1'b1; tmr_dwell = {1'b0, t_purge_b_q}; end
                ST_ABORT:   begin tmr_load = 1'b1; tmr_dwell = {1'b0, t_purge_a_q}; end
                default:    tmr_restart = 1'b1;
            endcase
        end
    end

    ald_tick_timer #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_timer (
        .clk_i     (clk),
        .rst_ni    (rst),
        .load_i    (tmr_load),
        .restart_i (tmr_restart),
        .dwell_i   (tmr_dwell),
        .expired_o (tmr_expired)
    );

    assign mask_d = gap_d ? close_gas(state_mask(state_d)) : state_mask(state_d);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            gap_q         <= 1'b0;
            gap_tgt_q     <= ST_IDLE;
            mask_q        <= MASK_OFF;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            fault_q       <= 1'b0;
            cycle_count_q <= '0;
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            gap_tgt_q <= gap_tgt_d;
            mask_q    <= mask_d;
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= (state_d == ST_DONE);
            if (accept)
                fault_q <= 1'b0;
            else if ((state_d == ST_ABORT) && (state_q != ST_ABORT))
                fault_q <= 1'b1;
            if (accept)
                cycle_count_q <= '0;
            else if (count_inc)
                cycle_count_q <= cycle_count_q + CYCLE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            t_pulse_a_q <= '0;
            t_purge_a_q <= '0;
            t_pulse_b_q <= '0;
            t_purge_b_q <= '0;
            n_cycles_q  <= '0;
        end else if (accept) begin
            t_pulse_a_q <= t_pulse_a;
            t_purge_a_q <= t_purge_a;
            t_pulse_b_q <= t_pulse_b;
            t_purge_b_q <= t_purge_b;
            n_cycles_q  <= n_cycles;
        end
    end

    assign sv1         = mask_q.sv1;
    assign sv2         = mask_q.sv2;
    assign sv3         = mask_q.sv3;
    assign vv1         = mask_q.vv1;
    assign heater_en   = mask_q.heater_en;
    assign busy        = busy_q;
    assign done        = done_q;
    assign fault       = fault_q;
    assign state       = state_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_ald_cycle_sequencer.sv
// tb/tb_ald_cycle_sequencer.sv - self-checking bench for ald_cycle_sequencer
module tb_ald_cycle_sequencer;

    localparam int TD  = 4;
    localparam int TW  = 8;
    localparam int CW  = 8;
    localparam int PTO = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          temp_ok = 1'b1;
    logic [TW-1:0] t_pulse_a = '0, t_purge_a = '0, t_pulse_b = '0, t_purge_b = '0;
    logic [CW-1:0] n_cycles = '0;
    logic          sv1, sv2, sv3, vv1, heater_en, busy, done, fault;
    logic [2:0]    state;
    logic [CW-1:0] cycle_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ald_cycle_sequencer #(
        .TICK_DIV   (TD),
        .TIME_W     (TW),
        .CYCLE_W    (CW),
        .PREHEAT_TO (PTO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .temp_ok     (temp_ok),
        .t_pulse_a   (t_pulse_a),
        .t_purge_a   (t_purge_a),
        .t_pulse_b   (t_pulse_b),
        .t_purge_b   (t_purge_b),
        .n_cycles    (n_cycles),
        .sv1         (sv1),
        .sv2         (sv2),
        .sv3         (sv3),
        .vv1         (vv1),
        .heater_en   (heater_en),
        .busy        (busy),
        .done        (done),
        .fault       (fault),
        .state       (state),
        .cycle_count (cycle_count)
    );

    // Output bit positions in the packed view {heater_en, vv1, sv3, sv2, sv1}.
    localparam logic [4:0] O_S1 = 5'b00001;
    localparam logic [4:0] O_S2 = 5'b00010;
    localparam logic [4:0] O_S3 = 5'b00100;
    localparam logic [4:0] O_V  = 5'b01000;
    localparam logic [4:0] O_H  = 5'b10000;

    typedef struct {
        logic [2:0] st;
        logic [4:0] outs;
        int         len;
        int         cc;
        logic       dn;
    } seg_t;

    seg_t segs[$];

    function automatic logic [4:0] outs();
        return {heater_en, vv1, sv3, sv2, sv1};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int dwell(input int t);
        return ((t == 0) ? 1 : t) * TD;
    endfunction

    function automatic void push(input logic [2:0] st, input logic [4:0] o, input int len,
                                 input int cc, input logic dn);
        seg_t s;
        s.st = st; s.outs = o; s.len = len; s.cc = cc; s.dn = dn;
        segs.push_back(s);
    endfunction

    // Expected timeline of a clean run with temp_ok already high, written as
    // (state, outputs, length) segments straight from the cycle description.
    task automatic build_run(input int ta, input int tpa, input int tb, input int tpb, input int n);
        segs.delete();
        if (n == 0) begin
            push(3'd6, 5'b0, 1, 0, 1'b1);
            return;
        end
        push(3'd1, O_H | O_V, 1, 0, 1'b0);
        for (int c = 0; c < n; c++) begin
            push(3'd2, O_H | O_V | O_S1, dwell(ta), c, 1'b0);
            push(3'd2, O_H | O_V, 1, c, 1'b0);
            push(3'd3, O_H | O_V | O_S2, dwell(tpa), c, 1'b0);
            push(3'd4, O_H | O_V | O_S3, dwell(tb), c, 1'b0);
            push(3'd4, O_H | O_V, 1, c, 1'b0);
            push(3'd5, O_H | O_V | O_S2, dwell(tpb), c, 1'b0);
        end
        push(3'd6, 5'b0, 1, n, 1'b1);
    endtask

    // Returns on the first cycle after acceptance (two sync flops + edge detect).
    task automatic start_run(input int ta, input int tpa, input int tb, input int tpb, input int n);
        t_pulse_a = TW'(ta);
        t_purge_a = TW'(tpa);
        t_pulse_b = TW'(tb);
        t_purge_b = TW'(tpb);
        n_cycles  = CW'(n);
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        tick();
    endtask

    task automatic run_check(input int ta, input int tpa, input int tb, input int tpb, input int n,
                             input bit noise);
        int remaining;
        build_run(ta, tpa, tb, tpb, n);
        remaining = 0;
        foreach (segs[i]) remaining += segs[i].len;
        start_run(ta, tpa, tb, tpb, n);
        // Live inputs change after acceptance; the run must ignore them.
        t_pulse_a = TW'($urandom);
        t_purge_a = TW'($urandom);
        t_pulse_b = TW'($urandom);
        t_purge_b = TW'($urandom);
        n_cycles  = CW'($urandom);
        foreach (segs[i]) begin
            for (int k = 0; k < segs[i].len; k++) begin
                chk("run_state", 32'(state), 32'(segs[i].st));
                chk("run_outs", 32'(outs()), 32'(segs[i].outs));
                chk("run_busy", 32'(busy), 32'd1);
                chk("run_done", 32'(done), 32'(segs[i].dn));
                chk("run_cycle_count", 32'(cycle_count), 32'(segs[i].cc));
                chk("run_fault", 32'(fault), 32'd0);
                chk("run_sv1_sv3_excl", 32'(sv1 & sv3), 32'd0);
                remaining--;
                start = (noise && remaining > 6) ? 1'($urandom_range(0, 1)) : 1'b0;
                tick();
            end
        end
        chk("end_state", 32'(state), 32'd0);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_done", 32'(done), 32'd0);
        chk("end_outs", 32'(outs()), 32'd0);
        chk("end_cycle_count", 32'(cycle_count), 32'(n));
        repeat (3) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_outs", 32'(outs()), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_cycle_count", 32'(cycle_count), 32'd0);
        rst = 1'b1;
        repeat (3) tick();

        // Nominal two-cycle run, all dwells 3 ticks
        run_check(3, 3, 3, 3, 2, 1'b0);

        // Zero pulse length acts as one tick; start pulses while busy ignored
        run_check(0, 1, 1, 1, 1, 1'b1);

        // Randomised runs
        for (int r = 0; r < 3; r++)
            run_check(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(1, 3)), 1'b1);

        // Stop mid PULSE_B of the first cycle
        start_run(3, 3, 3, 3, 2);
        repeat (29) tick();
        chk("stop_pre_state", 32'(state), 32'd4);
        stop = 1'b1;
        tick();
        tick();
        tick();
        chk("stop_gap_gas", 32'(outs() & (O_S1 | O_S2 | O_S3)), 32'd0);
        tick();
        chk("abort_state", 32'(state), 32'd7);
        chk("abort_outs", 32'(outs()), 32'(O_V | O_S2));
        chk("abort_fault", 32'(fault), 32'd1);
        repeat (11) tick();
        chk("abort_last_state", 32'(state), 32'd7);
        tick();
        chk("abort_idle_state", 32'(state), 32'd0);
        chk("abort_idle_busy", 32'(busy), 32'd0);
        chk("abort_fault_sticky", 32'(fault), 32'd1);
        chk("abort_idle_outs", 32'(outs()), 32'd0);
        stop = 1'b0;
        repeat (3) tick();

        // Preheat timeout with temp_ok held low
        temp_ok = 1'b0;
        repeat (3) tick();
        start_run(3, 3, 3, 3, 1);
        chk("preheat_state", 32'(state), 32'd1);
        chk("preheat_fault_cleared", 32'(fault), 32'd0);
        chk("preheat_outs", 32'(outs()), 32'(O_H | O_V));
        for (int k = 1; k < 20; k++) begin
            tick();
            chk("preheat_no_precursor", 32'(outs() & (O_S1 | O_S3)), 32'd0);
        end
        chk("preheat_last_state", 32'(state), 32'd1);
        tick();
        chk("preheat_to_state", 32'(state), 32'd7);
        chk("preheat_to_fault", 32'(fault), 32'd1);
        chk("preheat_to_outs", 32'(outs()), 32'(O_V | O_S2));
        repeat (12) tick();
        chk("preheat_to_idle", 32'(state), 32'd0);
        temp_ok = 1'b1;
        repeat (3) tick();

        // Zero-cycle run: straight to DONE, clears fault, no valve activity
        run_check(2, 2, 2, 2, 0, 1'b0);

        // stop and start together: stop wins
        stop = 1'b1;
        repeat (3) tick();
        start = 1'b1;
        repeat (4) tick();
        chk("stopwins_state", 32'(state), 32'd0);
        chk("stopwins_busy", 32'(busy), 32'd0);
        stop = 1'b0;
        repeat (3) tick();
        chk("stopwins_held_start_state", 32'(state), 32'd0);
        start = 1'b0;
        repeat (3) tick();

        // Asynchronous reset mid PURGE_A with start held through it
        start_run(3, 3, 3, 3, 1);
        repeat (19) tick();
        chk("purge_a_state", 32'(state), 32'd3);
        start = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_outs", 32'(outs()), 32'd0);
        chk("async_rst_state", 32'(state), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_fault", 32'(fault), 32'd0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("held_start_no_restart", 32'(busy), 32'd0);
        end
        start = 1'b0;
        repeat (3) tick();
        start_run(3, 3, 3, 3, 1);
        chk("repress_state", 32'(state), 32'd1);
        chk("repress_busy", 32'(busy), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
